// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin modes.
// The held beat is tagged with its source channel for downstream demultiplexing.
module mux_stream_rr #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    input  logic            out_ready
);

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_chan_q;
    logic [SW-1:0] last_q;

    logic          load;
    logic          granted;
    logic [SW-1:0] grant;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] cand;
    logic [W-1:0]  chan_data [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            chan_data[i] = in_data[i*W +: W];
        end
    end

    // Search starts one past the last round-robin grant and wraps.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SW'((int'(last_q) + k) % N);
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        load = !out_valid_q || out_ready;
        if (mode) begin
            granted = rr_found;
            grant   = rr_idx;
        end else begin
            granted = (32'(sel) < N) && in_valid[sel];
            grant   = sel;
        end
    end

    // Gated by rst so no handshake completes while reset is asserted.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_ready[i] = !rst && load && granted && (grant == SW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SW'(N - 1);
        end else if (load) begin
            if (granted) begin
                out_valid_q <= 1'b1;
                out_data_q  <= chan_data[grant];
                out_chan_q  <= grant;
                if (mode) begin
                    last_q <= grant;
                end
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed bench for mux_stream_rr (N=4, W=8): reset, round-robin, sparse,
// backpressure, fixed select and mode-switch sequences with hand-computed results.
module tb_mux_stream_rr;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_chan;
    logic          out_ready;

    int compared   = 0;
    int mismatched = 0;

    mux_stream_rr #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [SW-1:0] ch, input logic [W-1:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        // Round-robin, all valid: pointer resets to 3 so channel 0 goes first.
        chk("rr_ready0", 32'(in_ready), 32'h1);
        step(); chk_beat("rr0", 2'd0, 8'hA0); chk("rr_ready1", 32'(in_ready), 32'h2);
        step(); chk_beat("rr1", 2'd1, 8'hA1); chk("rr_ready2", 32'(in_ready), 32'h4);
        step(); chk_beat("rr2", 2'd2, 8'hA2); chk("rr_ready3", 32'(in_ready), 32'h8);
        step(); chk_beat("rr3", 2'd3, 8'hA3); chk("rr_ready4", 32'(in_ready), 32'h1);
        step(); chk_beat("rr4", 2'd0, 8'hA0);
        step(); chk_beat("rr5", 2'd1, 8'hA1);

        // Sparse: channels 1 and 3, last = 1.
        in_valid = 4'b1010;
        #1; chk("sp_ready0", 32'(in_ready), 32'h8);
        step(); chk_beat("sp0", 2'd3, 8'hA3); chk("sp_ready1", 32'(in_ready), 32'h2);
        step(); chk_beat("sp1", 2'd1, 8'hA1); chk("sp_ready2", 32'(in_ready), 32'h8);
        step(); chk_beat("sp2", 2'd3, 8'hA3);
        step(); chk_beat("sp3", 2'd1, 8'hA1);

        // Backpressure with 0x5C held from channel 3.
        in_valid = 4'b1000;
        in_data[3*W +: W] = 8'h5C;
        step(); chk_beat("bp_load", 2'd3, 8'h5C);
        out_ready = 1'b0;
        in_valid  = 4'hF;
        #1; chk("bp_ready_init", 32'(in_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_beat("bp_hold", 2'd3, 8'h5C);
            chk("bp_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1; chk("bp_release_ready", 32'(in_ready), 32'h1);
        step(); chk_beat("bp_next", 2'd0, 8'hA0);
        in_data[3*W +: W] = 8'hA3;

        // Fixed select on channel 2.
        mode = 1'b0;
        sel  = 2'd2;
        #1; chk("fx_ready0", 32'(in_ready), 32'h4);
        step(); chk_beat("fx0", 2'd2, 8'hA2); chk("fx_ready1", 32'(in_ready), 32'h4);
        step(); chk_beat("fx1", 2'd2, 8'hA2);
        in_valid = 4'b1011;
        #1; chk("fx_nogrant_ready", 32'(in_ready), 32'h0);
        step(); chk("fx_drain_valid", 32'(out_valid), 32'd0);

        // Mode switch: round-robin grant to 2, three fixed beats on 0, then back.
        mode     = 1'b1;
        in_valid = 4'b0100;
        step(); chk_beat("ms_rr", 2'd2, 8'hA2);
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 4'hF;
        #1; chk("ms_fx_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_beat("ms_fx", 2'd0, 8'hA0);
        end
        mode = 1'b1;
        #1; chk("ms_back_ready", 32'(in_ready), 32'h8);
        step(); chk_beat("ms_back", 2'd3, 8'hA3);

        // Reset mid-stream while a beat is held.
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        step();
        rst = 1'b0;
        #1; chk("post_rst_ready", 32'(in_ready), 32'h1);
        step(); chk_beat("post_rst", 2'd0, 8'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mux_stream_rr.md
# mux_stream_rr

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking on every channel and two selection modes: fixed select (steered by a `sel` input, the sequential generalisation of our 4:1 select-line muxes) and fair round-robin arbitration. It sits between multiple producer blocks and a single consumer. It registers the selected beat, and tags the beat with its source channel so downstream logic can demultiplex.

## Interface
- `N`, 4, number of input channels (2..16)
- `W`, 8, data width per channel in bits
- `SW`, `$clog2(N)`, channel-index width (derived; do not override)

- `clk` input 1 — sole clock; all state updates on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `in_valid` input N — bit i: channel i presents a beat
- `in_data` input N*W — channel i data at bits [i*W +: W]
- `in_ready` output N — bit i: channel i beat accepted this cycle (combinational)
- `mode` input 1 — 0 = fixed select, 1 = round-robin
- `sel` input SW — channel index used when `mode`=0
- `out_valid` output 1 — output register holds a beat
- `out_data` output W — registered beat data
- `out_chan` output SW — source channel of the held beat
- `out_ready` input 1 — consumer accepts the beat

## Operation
- Transfer on any port occurs when valid and ready are both high at the rising edge.
- Load enable: `load = !out_valid || out_ready`. No new beat is granted when `load`=0.
- Grant, mode 0: the grant goes to channel `sel` if `sel` < N and `in_valid[sel]`=1; otherwise there is no grant. Other channels are never granted.
- Grant, mode 1: search channels starting at `(last+1) mod N` with wrap-around, and grant the first with `in_valid`=1. There is no grant if none is valid.
- `last` holds the index of the most recent round-robin grant.
  - It updates only on a mode-1 transfer.
  - Mode-0 transfers leave it unchanged.
- `in_ready[i] = load && granted && grant==i`. At most one bit is high per cycle, and `in_ready` never depends on other channels' ready.
- On a transfer: `out_data`←granted data, `out_chan`←grant, `out_valid`←1.
- If `out_ready`=1 and there is no grant, `out_valid`←0.
- If `out_ready`=0 while `out_valid`=1, `out_data`/`out_chan` hold stable.
- A producer may drop `in_valid` without a transfer. The block drops no data and duplicates no data.
- `mode`/`sel` changes take effect in the same cycle's grant. A held output beat is unaffected.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `last`=N-1.
  - Because `last` resets to N-1, channel 0 has first round-robin priority.
  - `in_ready` is all-zero while `rst`=1.
- Latency: 1 cycle from the input transfer edge to `out_valid`=1.
- Throughput: 1 beat/cycle sustained when `out_ready`=1 is held high (drain and refill occur on the same edge).
- Backpressure: with `out_ready`=0 and `out_valid`=1, all `in_ready` are 0.
- Reset mid-operation: a held beat is discarded and the round-robin pointer returns to N-1. Stream operation resumes on the first edge after `rst` deasserts.
- Combinational paths:
  - `in_valid`, `mode`, `sel`, `out_ready` → `in_ready` (no loops through the output).
  - `out_*` are purely registered.

## Test plan
- Reset: assert `rst` mid-stream with `out_valid`=1 → `out_valid`=0, `out_data`=0 and `in_ready`=0 immediately. After release, mode 1 with all channels valid → the first beat has `out_chan`=0.
- Round-robin fairness: N=4, all `in_valid`=1 with constant data 0xA0..0xA3, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0,1 with one beat per cycle. Each `in_ready` is high once per 4 cycles.
- Sparse round-robin: only channels 1 and 3 valid and `last`=1 → grants 3,1,3,1. Channel 0 and channel 2 `in_ready` stay 0.
- Fixed select: mode 0, `sel`=2, all valid → only channel 2 is accepted every cycle with `out_chan`=2. Setting `sel`=2 with `in_valid[2]`=0 → no grant, and `out_valid` falls the cycle after the last drain.
- Backpressure: `out_ready`=0 for 5 cycles with a beat 0x5C held → `out_data`=0x5C stable and all `in_ready`=0. On `out_ready`=1, the next beat loads on the same edge.
- Mode switch: mode 1 after grant to channel 2, switch to mode 0 `sel`=0 for 3 beats, then back to mode 1 with all valid → the next round-robin grant is channel 3 (pointer preserved).
